// File: rtl/aib_axi_follower_port.sv
// aib_axi_follower_port: parametrised AXI4 follower port stage with 2-entry skid buffers, outstanding limits and error flags.
// Optional watchdog: define AXI_FOLLOWER_TIMEOUT_EN.
module aib_axi_follower_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem [2];
    logic         wp, rp, rdy_en;
    logic [1:0]   cnt, cnt_nx;
    logic         push, pop;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = cnt != 2'd0;
    assign out_data  = mem[rp];
    assign cnt_nx    = cnt + 2'(push) - 2'(pop);
    // rdy_en delays the first ready by one cycle after reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= 2'd0;
            rdy_en   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            if (push) mem[wp] <= in_data;
            wp       <= wp ^ push;
            rp       <= rp ^ pop;
            cnt      <= cnt_nx;
            rdy_en   <= 1'b1;
            in_ready <= rdy_en & (cnt_nx < 2'd2);
        end
    end
endmodule

module aib_axi_follower_port #(
    parameter int ADDRWIDTH          = 32,
    parameter int IDWIDTH            = 4,
    parameter int DATAWIDTH          = 128,
    parameter int MAX_WR_OUTSTANDING = 8,
    parameter int MAX_RD_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr_n,
    input  logic [IDWIDTH-1:0]     s_axi_awid,
    input  logic [ADDRWIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]             s_axi_awlen,
    input  logic [2:0]             s_axi_awsize,
    input  logic [1:0]             s_axi_awburst,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [IDWIDTH-1:0]     s_axi_wid,
    input  logic [DATAWIDTH-1:0]   s_axi_wdata,
    input  logic [DATAWIDTH/8-1:0] s_axi_wstrb,
    input  logic                   s_axi_wlast,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [IDWIDTH-1:0]     s_axi_bid,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [IDWIDTH-1:0]     s_axi_arid,
    input  logic [ADDRWIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]             s_axi_arlen,
    input  logic [2:0]             s_axi_arsize,
    input  logic [1:0]             s_axi_arburst,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [IDWIDTH-1:0]     s_axi_rid,
    output logic [DATAWIDTH-1:0]   s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rlast,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [IDWIDTH-1:0]     m_axi_awid,
    output logic [ADDRWIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic [1:0]             m_axi_awburst,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [IDWIDTH-1:0]     m_axi_wid,
    output logic [DATAWIDTH-1:0]   m_axi_wdata,
    output logic [DATAWIDTH/8-1:0] m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [IDWIDTH-1:0]     m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic [IDWIDTH-1:0]     m_axi_arid,
    output logic [ADDRWIDTH-1:0]   m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [IDWIDTH-1:0]     m_axi_rid,
    input  logic [DATAWIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    input  logic                   clr_err,
    output logic [7:0]             wr_outstanding,
    output logic [7:0]             rd_outstanding,
    output logic                   proto_err,
    output logic                   timeout_err,
    output logic                   idle
);
    localparam int AW_W = IDWIDTH + ADDRWIDTH + 13;
    localparam int W_W  = IDWIDTH + DATAWIDTH + DATAWIDTH/8 + 1;
    localparam int B_W  = IDWIDTH + 2;
    localparam int R_W  = IDWIDTH + DATAWIDTH + 3;
    logic aw_v, ar_v, wr_ok, rd_ok;
    logic aw_hs, b_hs, ar_hs, r_hs, rl_hs;
    assign wr_ok         = wr_outstanding < 8'(MAX_WR_OUTSTANDING);
    assign rd_ok         = rd_outstanding < 8'(MAX_RD_OUTSTANDING);
    assign m_axi_awvalid = aw_v & wr_ok;
    assign m_axi_arvalid = ar_v & rd_ok;
    assign aw_hs         = m_axi_awvalid & m_axi_awready;
    assign ar_hs         = m_axi_arvalid & m_axi_arready;
    assign b_hs          = m_axi_bvalid & m_axi_bready;
    assign r_hs          = m_axi_rvalid & m_axi_rready;
    assign rl_hs         = r_hs & m_axi_rlast;

    aib_axi_follower_skid #(.W(AW_W)) u_aw (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(s_axi_awvalid), .in_ready(s_axi_awready),
        .in_data({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst}),
        .out_valid(aw_v), .out_ready(m_axi_awready & wr_ok),
        .out_data({m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst})
    );
    aib_axi_follower_skid #(.W(W_W)) u_w (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
        .in_data({s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast}),
        .out_valid(m_axi_wvalid), .out_ready(m_axi_wready),
        .out_data({m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast})
    );
    aib_axi_follower_skid #(.W(B_W)) u_b (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(m_axi_bvalid), .in_ready(m_axi_bready),
        .in_data({m_axi_bid, m_axi_bresp}),
        .out_valid(s_axi_bvalid), .out_ready(s_axi_bready),
        .out_data({s_axi_bid, s_axi_bresp})
    );
    aib_axi_follower_skid #(.W(AW_W)) u_ar (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(s_axi_arvalid), .in_ready(s_axi_arready),
        .in_data({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst}),
        .out_valid(ar_v), .out_ready(m_axi_arready & rd_ok),
        .out_data({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst})
    );
    aib_axi_follower_skid #(.W(R_W)) u_r (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(m_axi_rvalid), .in_ready(m_axi_rready),
        .in_data({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
        .out_valid(s_axi_rvalid), .out_ready(s_axi_rready),
        .out_data({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast})
    );

    // a response arriving with its counter already at 0 is flagged but still forwarded
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            wr_outstanding <= 8'd0;
            rd_outstanding <= 8'd0;
            proto_err      <= 1'b0;
        end else begin
            wr_outstanding <= (aw_hs & ~b_hs) ? wr_outstanding + 8'd1 :
                              (b_hs & ~aw_hs & wr_outstanding != 8'd0) ? wr_outstanding - 8'd1 : wr_outstanding;
            rd_outstanding <= (ar_hs & ~rl_hs) ? rd_outstanding + 8'd1 :
                              (rl_hs & ~ar_hs & rd_outstanding != 8'd0) ? rd_outstanding - 8'd1 : rd_outstanding;
            proto_err      <= (proto_err & ~clr_err) | (b_hs & wr_outstanding == 8'd0) |
                              (rl_hs & rd_outstanding == 8'd0);
        end
    end

`ifdef AXI_FOLLOWER_TIMEOUT_EN
    logic [31:0] wd;
    logic        busy;
    assign busy = (wr_outstanding | rd_outstanding) != 8'd0;
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            wd          <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            wd          <= (!busy | b_hs | r_hs) ? 32'd0 : wd + 32'd1;
            timeout_err <= (timeout_err & ~clr_err) |
                           (busy & ~(b_hs | r_hs) & (wd >= 32'(TIMEOUT_CYCLES - 1)));
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign idle = ~(aw_v | m_axi_wvalid | s_axi_bvalid | ar_v | s_axi_rvalid) &
                  (wr_outstanding == 8'd0) & (rd_outstanding == 8'd0);
endmodule

// File: tb/tb_aib_axi_follower_port.sv
// tb_aib_axi_follower_port: directed self-checking bench for aib_axi_follower_port.
module tb_aib_axi_follower_port;
    localparam int AWD = 32, IDW = 4, DW = 128, TO = 64;
    logic clk_wr = 1'b0, rst_wr_n = 1'b0;
    logic [IDW-1:0] s_axi_awid = '0, s_axi_wid = '0, s_axi_bid, s_axi_arid = '0, s_axi_rid;
    logic [AWD-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0] s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0] s_axi_awsize = '0, s_axi_arsize = '0;
    logic [1:0] s_axi_awburst = '0, s_axi_arburst = '0, s_axi_bresp, s_axi_rresp;
    logic s_axi_awvalid = 0, s_axi_awready, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
    logic [DW-1:0] s_axi_wdata = '0, s_axi_rdata;
    logic [DW/8-1:0] s_axi_wstrb = '1;
    logic s_axi_bvalid, s_axi_bready = 1, s_axi_arvalid = 0, s_axi_arready;
    logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 1;
    logic [IDW-1:0] m_axi_awid, m_axi_wid, m_axi_bid = '0, m_axi_arid, m_axi_rid = '0;
    logic [AWD-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0] m_axi_awlen, m_axi_arlen;
    logic [2:0] m_axi_awsize, m_axi_arsize;
    logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp = '0, m_axi_rresp = '0;
    logic m_axi_awvalid, m_axi_awready = 1, m_axi_wlast, m_axi_wvalid, m_axi_wready = 1;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata = '0;
    logic [DW/8-1:0] m_axi_wstrb;
    logic m_axi_bvalid = 0, m_axi_bready, m_axi_arvalid, m_axi_arready = 1;
    logic m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;
    logic clr_err = 0, proto_err, timeout_err, idle;
    logic [7:0] wr_outstanding, rd_outstanding;
    int n_run = 0, n_fail = 0, aw_hs = 0;
    logic [DW:0] r_q[$];

    aib_axi_follower_port #(.ADDRWIDTH(AWD), .IDWIDTH(IDW), .DATAWIDTH(DW),
        .MAX_WR_OUTSTANDING(4), .MAX_RD_OUTSTANDING(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .clr_err(clr_err), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .proto_err(proto_err), .timeout_err(timeout_err), .idle(idle)
    );

    always #5 clk_wr = ~clk_wr;

    always @(posedge clk_wr) begin
        if (m_axi_awvalid && m_axi_awready) aw_hs <= aw_hs + 1;
        if (s_axi_rvalid && s_axi_rready) r_q.push_back({s_axi_rlast, s_axi_rdata});
    end

    function automatic logic [DW-1:0] pat(int i);
        return {32'hA5A50000 + 32'(i), 32'h5A5A0000 + 32'(i), 32'hC3C30000 + 32'(i), 32'h3C3C0000 + 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_aw(input logic [AWD-1:0] a);
        logic hs = 0;
        s_axi_awvalid = 1;
        s_axi_awaddr  = a;
        for (int k = 0; k < 50 && !hs; k++) begin
            hs = s_axi_awready;
            @(negedge clk_wr);
        end
        if (!hs) check("aw_accept_timeout", 0, 1);
        s_axi_awvalid = 0;
    endtask

    task automatic send_ar(input logic [AWD-1:0] a, input logic [7:0] len);
        logic hs = 0;
        s_axi_arvalid = 1;
        s_axi_araddr  = a;
        s_axi_arlen   = len;
        for (int k = 0; k < 50 && !hs; k++) begin
            hs = s_axi_arready;
            @(negedge clk_wr);
        end
        if (!hs) check("ar_accept_timeout", 0, 1);
        s_axi_arvalid = 0;
    endtask

    initial begin
        int aw0, rb, j;
        logic saw_low, hs;
        repeat (3) @(negedge clk_wr);
        check("rst_awready", s_axi_awready, 0);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_idle", idle, 1);
        check("rst_wr_out", wr_outstanding, 0);
        check("rst_proto", proto_err, 0);
        check("rst_wdata", m_axi_wdata, 0);
        rst_wr_n = 1;
        @(negedge clk_wr);
        check("first_cyc_wready", s_axi_wready, 0);
        @(negedge clk_wr);
        check("wready_up", s_axi_wready, 1);

        // streaming W, 16 beats back to back
        for (int i = 0; i <= 16; i++) begin
            check("w_stream_valid", m_axi_wvalid, i > 0);
            if (i > 0) check("w_stream_data", m_axi_wdata, pat(i - 1));
            if (i < 16) check("w_stream_rdy", s_axi_wready, 1);
            s_axi_wvalid = i < 16;
            s_axi_wdata  = pat(i);
            s_axi_wlast  = 1;
            @(negedge clk_wr);
        end
        check("w_stream_end", m_axi_wvalid, 0);

        // outstanding write limit of 4
        aw0 = aw_hs;
        for (int i = 0; i < 6; i++) send_aw(32'h1000 + 32'(i * 16));
        repeat (3) @(negedge clk_wr);
        check("lim_hs4", aw_hs - aw0, 4);
        check("lim_awvalid", m_axi_awvalid, 0);
        check("lim_wr_out", wr_outstanding, 4);
        check("lim_awready", s_axi_awready, 0);
        check("lim_head_addr", m_axi_awaddr, 32'h1040);
        m_axi_bid = 4'h3;
        check("lim_bready", m_axi_bready, 1);
        m_axi_bvalid = 1;
        @(negedge clk_wr);
        m_axi_bvalid = 0;
        check("b_fwd_valid", s_axi_bvalid, 1);
        check("b_fwd_id", s_axi_bid, 4'h3);
        check("b_dec", wr_outstanding, 3);
        check("gate_open", m_axi_awvalid, 1);
        @(negedge clk_wr);
        check("one_more_aw", wr_outstanding, 4);
        check("gate_shut", m_axi_awvalid, 0);
        check("lim_hs5", aw_hs - aw0, 5);
        m_axi_bvalid = 1;
        repeat (5) @(negedge clk_wr);
        m_axi_bvalid = 0;
        repeat (3) @(negedge clk_wr);
        check("drain_wr_out", wr_outstanding, 0);
        check("drain_hs6", aw_hs - aw0, 6);
        check("drain_proto", proto_err, 0);

        // protocol error: B with nothing outstanding
        m_axi_bid = 4'h5;
        m_axi_bvalid = 1;
        @(negedge clk_wr);
        m_axi_bvalid = 0;
        check("perr_set", proto_err, 1);
        check("perr_b_fwd", s_axi_bvalid, 1);
        check("perr_b_id", s_axi_bid, 4'h5);
        check("perr_wr_out", wr_outstanding, 0);
        clr_err = 1;
        @(negedge clk_wr);
        clr_err = 0;
        check("perr_clr", proto_err, 0);

        // simultaneous AR and R-last with rd_outstanding=3
        for (int i = 0; i < 3; i++) send_ar(32'h2000 + 32'(i * 64), 0);
        repeat (2) @(negedge clk_wr);
        check("rd_out3", rd_outstanding, 3);
        s_axi_arvalid = 1;
        s_axi_araddr  = 32'h3000;
        @(negedge clk_wr);
        s_axi_arvalid = 0;
        check("sim_arvalid", m_axi_arvalid, 1);
        check("sim_araddr", m_axi_araddr, 32'h3000);
        m_axi_rvalid = 1;
        m_axi_rlast  = 1;
        m_axi_rdata  = pat(50);
        @(negedge clk_wr);
        m_axi_rvalid = 0;
        check("sim_rd_out", rd_outstanding, 3);
        check("sim_r_fwd", {s_axi_rlast, s_axi_rdata}, {1'b1, pat(50)});
        m_axi_rvalid = 1;
        repeat (3) @(negedge clk_wr);
        m_axi_rvalid = 0;
        repeat (2) @(negedge clk_wr);
        check("rd_drain", rd_outstanding, 0);

        // 8-beat burst with s-side rready 1010...
        send_ar(32'h4000, 8'd7);
        repeat (2) @(negedge clk_wr);
        check("burst_rd_out", rd_outstanding, 1);
        rb = r_q.size();
        j = 0;
        saw_low = 0;
        for (int c = 0; c < 100 && j < 8; c++) begin
            m_axi_rvalid = 1;
            m_axi_rdata  = pat(100 + j);
            m_axi_rlast  = j == 7;
            s_axi_rready = c % 2 == 0;
            hs = m_axi_rready;
            if (!hs) saw_low = 1;
            @(negedge clk_wr);
            if (hs) j++;
        end
        m_axi_rvalid = 0;
        m_axi_rlast  = 0;
        s_axi_rready = 1;
        repeat (4) @(negedge clk_wr);
        check("burst_sent", j, 8);
        check("burst_bp_seen", saw_low, 1);
        check("burst_count", r_q.size() - rb, 8);
        for (int k = 0; k < 8; k++)
            if (rb + k < r_q.size()) check("burst_beat", r_q[rb + k], {k == 7, pat(100 + k)});
        check("burst_rd_out0", rd_outstanding, 0);
        check("burst_proto", proto_err, 0);

        // watchdog: one AR, no R
        send_ar(32'h5000, 0);
        repeat (30) @(negedge clk_wr);
        check("to_early", timeout_err, 0);
        check("to_busy_idle", idle, 0);
        repeat (40) @(negedge clk_wr);
`ifdef AXI_FOLLOWER_TIMEOUT_EN
        check("to_set", timeout_err, 1);
`else
        check("to_off", timeout_err, 0);
`endif
        m_axi_rvalid = 1;
        m_axi_rlast  = 1;
        @(negedge clk_wr);
        m_axi_rvalid = 0;
        m_axi_rlast  = 0;
        clr_err = 1;
        @(negedge clk_wr);
        clr_err = 0;
        repeat (2) @(negedge clk_wr);
        check("to_clr", timeout_err, 0);
        check("end_idle", idle, 1);
        check("end_rd_out", rd_outstanding, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
